// File: rtl/mix_char_tx.sv
// -----------------------------------------------------------------------------
// mix_char_tx
// Output stage of the MIX core. Accepts one 30-bit MIX word (five 6-bit
// character codes), translates each code to ASCII and shifts the characters
// out on a UART line as 8N1 frames. It can optionally append CR LF.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   word_in     five MIX codes; bits[29:24] are sent first, bits[5:0] last
//   word_eol    sampled with word_in; 1 appends CR (0x0D) and LF (0x0A)
//   word_valid  word_in / word_eol are valid
//   word_ready  block can accept a word (high only while idle)
//   tx          UART line, idle high
//   busy        high from acceptance until the last stop bit has been sent
//
// Parameter
//   CLKS_PER_BIT  clock cycles per UART bit, 2..65535
// -----------------------------------------------------------------------------
module mix_char_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] word_in,
    input  logic        word_eol,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [2:0]      r_char;
    logic [29:0]     r_word;
    logic            r_eol;
    logic            r_tx;
    logic            r_busy;
    logic            r_ready;

    logic            w_accept;
    logic            w_baud_last;
    logic            w_last_char;
    logic [5:0]      w_code;
    logic [7:0]      w_ascii;
    logic            w_tx;

    // MIX character code to 7-bit ASCII (bit 7 always 0)
    function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
        logic [7:0] c;
        c = {2'b00, code};
        if (code == 6'd0) begin
            mix_to_ascii = 8'h20;
        end else if (code <= 6'd9) begin
            mix_to_ascii = c + 8'h40;
        end else if (code == 6'd10) begin
            mix_to_ascii = 8'h23;
        end else if (code <= 6'd19) begin
            mix_to_ascii = c + 8'h3F;
        end else if (code == 6'd20) begin
            mix_to_ascii = 8'h25;
        end else if (code == 6'd21) begin
            mix_to_ascii = 8'h26;
        end else if (code <= 6'd29) begin
            mix_to_ascii = c + 8'h3D;
        end else if (code <= 6'd39) begin
            mix_to_ascii = c + 8'h12;
        end else begin
            case (code)
                6'd40:   mix_to_ascii = 8'h2E;
                6'd41:   mix_to_ascii = 8'h2C;
                6'd42:   mix_to_ascii = 8'h28;
                6'd43:   mix_to_ascii = 8'h29;
                6'd44:   mix_to_ascii = 8'h2B;
                6'd45:   mix_to_ascii = 8'h2D;
                6'd46:   mix_to_ascii = 8'h2A;
                6'd47:   mix_to_ascii = 8'h2F;
                6'd48:   mix_to_ascii = 8'h3D;
                6'd49:   mix_to_ascii = 8'h24;
                6'd50:   mix_to_ascii = 8'h3C;
                6'd51:   mix_to_ascii = 8'h3E;
                6'd52:   mix_to_ascii = 8'h40;
                6'd53:   mix_to_ascii = 8'h3B;
                6'd54:   mix_to_ascii = 8'h3A;
                6'd55:   mix_to_ascii = 8'h27;
                default: mix_to_ascii = 8'h3F;
            endcase
        end
    endfunction

    assign w_accept    = word_valid && r_ready;
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_last_char = (r_char == (r_eol ? 3'd6 : 3'd4));

    // Select the character being sent: five MIX codes, then optional CR LF
    always_comb begin
        w_code  = 6'd0;
        w_ascii = 8'h00;
        case (r_char)
            3'd0:    w_code = r_word[29:24];
            3'd1:    w_code = r_word[23:18];
            3'd2:    w_code = r_word[17:12];
            3'd3:    w_code = r_word[11:6];
            3'd4:    w_code = r_word[5:0];
            default: w_code = 6'd0;
        endcase
        case (r_char)
            3'd5:    w_ascii = 8'h0D;
            3'd6:    w_ascii = 8'h0A;
            default: w_ascii = mix_to_ascii(w_code);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_next = ST_DATA;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_baud_last && (r_bit == 3'd7)) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    w_state_next = w_last_char ? ST_IDLE : ST_START;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM output logic: line level for the current state
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            ST_IDLE:  w_tx = 1'b1;
            ST_START: w_tx = 1'b0;
            ST_DATA:  w_tx = w_ascii[r_bit];
            ST_STOP:  w_tx = 1'b1;
            default:  w_tx = 1'b1;
        endcase
    end

    // Word latch plus baud, bit and character counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= 30'd0;
            r_eol  <= 1'b0;
            r_baud <= '0;
            r_bit  <= 3'd0;
            r_char <= 3'd0;
        end else if (w_accept) begin
            r_word <= word_in;
            r_eol  <= word_eol;
            r_baud <= '0;
            r_bit  <= 3'd0;
            r_char <= 3'd0;
        end else if (r_state != ST_IDLE) begin
            if (w_baud_last) begin
                r_baud <= '0;
                // bit index wraps 7 -> 0 naturally, ready for the next frame
                if (r_state == ST_DATA) begin
                    r_bit <= r_bit + 3'd1;
                end else begin
                    r_bit <= r_bit;
                end
                if ((r_state == ST_STOP) && !w_last_char) begin
                    r_char <= r_char + 3'd1;
                end else begin
                    r_char <= r_char;
                end
            end else begin
                r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_baud <= '0;
        end
    end

    // Registered outputs. tx follows the state one cycle later, so the start
    // bit appears the cycle after acceptance. busy/ready look at the next
    // state so they change on the acceptance edge and the return-to-idle edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_tx    <= w_tx;
            r_busy  <= (w_state_next != ST_IDLE);
            r_ready <= (w_state_next == ST_IDLE);
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign word_ready = r_ready;

endmodule

// File: tb/tb_mix_char_tx.sv
module tb_mix_char_tx;

    localparam int C = 4;

    logic        clk;
    logic        reset;
    logic [29:0] word_in;
    logic        word_eol;
    logic        word_valid;
    logic        word_ready;
    logic        tx;
    logic        busy;

    int nerr;
    int nchk;

    mix_char_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_eol   (word_eol),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx         (tx),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one word and decode nch frames sampled mid-bit.
    // hold=1 keeps word_valid high with junk data during the transfer and
    // presents next_w on the cycle word_ready returns.
    task automatic xfer(input string tag, input logic [29:0] w, input logic eol,
                        input int nch, input logic [55:0] exp,
                        input logic hold, input logic [29:0] next_w);
        int          busy_cnt;
        logic [7:0]  rx;
        logic        frame_ok;
        chk({tag, "_ready_pre"}, {31'd0, word_ready}, 32'd1);
        word_in    = w;
        word_eol   = eol;
        word_valid = 1'b1;
        @(negedge clk);
        if (!hold) word_valid = 1'b0;
        chk({tag, "_tx_at_accept"}, {31'd0, tx}, 32'd1);
        chk({tag, "_busy_at_accept"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ready_at_accept"}, {31'd0, word_ready}, 32'd0);
        busy_cnt = int'(busy);
        for (int k = 0; k < nch; k++) begin
            rx       = 8'h00;
            frame_ok = 1'b1;
            for (int j = 0; j < 10 * C; j++) begin
                @(negedge clk);
                if (hold) word_in = 30'h2AAAAAAA ^ 30'(k * 64 + j);
                busy_cnt += int'(busy);
                if ((k == 0) && (j == 0))
                    chk({tag, "_start_latency"}, {31'd0, tx}, 32'd0);
                if ((j % C) == (C / 2)) begin
                    if (j / C == 0)      frame_ok &= (tx == 1'b0);
                    else if (j / C == 9) frame_ok &= (tx == 1'b1);
                    else                 rx[j / C - 1] = tx;
                end
            end
            chk($sformatf("%s_frame%0d", tag, k), {31'd0, frame_ok}, 32'd1);
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, rx}, {24'd0, exp[8*k +: 8]});
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(10 * C * nch));
        chk({tag, "_ready_end"}, {31'd0, word_ready}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        if (hold) word_in = next_w;
    endtask

    logic [29:0] w_hello;
    logic [29:0] w_abcde;
    logic        ok;

    initial begin
        nerr       = 0;
        nchk       = 0;
        reset      = 1'b1;
        word_in    = 30'd0;
        word_eol   = 1'b0;
        word_valid = 1'b0;
        w_hello    = {6'o10, 6'o05, 6'o15, 6'o15, 6'o20};
        w_abcde    = {6'o01, 6'o02, 6'o03, 6'o04, 6'o05};

        // Reset held five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_tx", {31'd0, tx}, 32'd1);
            chk("reset_ready", {31'd0, word_ready}, 32'd1);
            chk("reset_busy", {31'd0, busy}, 32'd0);
        end
        reset = 1'b0;

        // Idle line with no valid
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok &= (tx == 1'b1) && (busy == 1'b0) && (word_ready == 1'b1);
        end
        chk("idle_100", {31'd0, ok}, 32'd1);

        // HELLO without and with CR LF
        xfer("hello", w_hello, 1'b0, 5,
             {8'h00, 8'h00, 8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48}, 1'b0, 30'd0);
        @(negedge clk);
        xfer("hello_eol", w_hello, 1'b1, 7,
             {8'h0A, 8'h0D, 8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48}, 1'b0, 30'd0);

        // Translation sweep across two words
        xfer("sweep_a", {6'd0, 6'd10, 6'd20, 6'd21, 6'd30}, 1'b0, 5,
             {8'h00, 8'h00, 8'h30, 8'h26, 8'h25, 8'h23, 8'h20}, 1'b0, 30'd0);
        xfer("sweep_b", {6'd39, 6'd55, 6'd56, 6'd63, 6'd0}, 1'b0, 5,
             {8'h00, 8'h00, 8'h20, 8'h3F, 8'h3F, 8'h27, 8'h39}, 1'b0, 30'd0);

        // Valid held high with changing data: only the word present when
        // ready returns is taken next
        xfer("hold_first", w_abcde, 1'b0, 5,
             {8'h00, 8'h00, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41}, 1'b1,
             {6'd29, 6'd39, 6'd22, 6'd1, 6'd0});
        xfer("hold_second", {6'd29, 6'd39, 6'd22, 6'd1, 6'd0}, 1'b0, 5,
             {8'h00, 8'h00, 8'h20, 8'h41, 8'h53, 8'h39, 8'h5A}, 1'b0, 30'd0);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok &= (tx == 1'b1) && (busy == 1'b0);
        end
        chk("hold_no_extra", {31'd0, ok}, 32'd1);

        // Reset during the data bits of character index 3
        word_in    = w_hello;
        word_eol   = 1'b0;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (31 * C + 2) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_ready", {31'd0, word_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        xfer("after_abort", w_abcde, 1'b0, 5,
             {8'h00, 8'h00, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41}, 1'b0, 30'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mix_char_tx.md
Name: mix_char_tx

Overview:
- Output stage of the MIX core: takes one 30-bit MIX word (five 6-bit MIX character codes) from the OUT-instruction datapath.
- Translates each code to ASCII and serialises it on the board UART line (8N1), optionally appending CR LF.
- Sits between the MIX I/O unit logic and the top-level tx pin.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- word_in  input  30  five MIX chars; byte1 = bits[29:24] sent first, byte5 = bits[5:0] last
- word_eol  input  1  sampled with word_in; 1 = append CR (0x0D), LF (0x0A) after byte5
- word_valid  input  1  word_in/word_eol valid
- word_ready  output  1  block can accept a word
- tx  output  1  UART line, idle high
- busy  output  1  high from acceptance until end of last stop bit

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: tx=1, word_ready=1, busy=0, state=IDLE, all counters 0.
- Reset asserted mid-frame aborts the transfer:
  - Next cycle: tx=1, word_ready=1, busy=0.
  - The partial character is lost.
- Handshake:
  - A transfer is accepted on a rising edge where word_valid && word_ready.
  - word_ready is high only in IDLE.
  - word_valid while not ready is ignored; the word is neither queued nor stalled.
  - The word and eol flag are latched on acceptance.
- Character count per word: 5, or 7 when eol=1.
- Translation (combinational ROM on the current 6-bit code):
  - 0 -> ' '
  - 1-9 -> 'A'-'I'
  - 10 (Δ) -> '#'
  - 11-19 -> 'J'-'R'
  - 20 (Σ) -> '%'
  - 21 (Π) -> '&'
  - 22-29 -> 'S'-'Z'
  - 30-39 -> '0'-'9'
  - 40-55 -> . , ( ) + - * / = $ < > @ ; : ' in that order
  - 56-63 -> '?' (0x3F)
- FSM states:
  - IDLE: ready=1. On acceptance go to START, char index=0, bit counter=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=ascii[bit] LSB first, each bit for CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if more characters remain: increment char index, go to START;
    - otherwise: go to IDLE, busy=0.
- Latency: tx falls on the first edge after the acceptance edge, i.e. acceptance at edge N gives tx=0 from edge N+1.
- Timing:
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
  - Frames are back-to-back with no extra idle cycles.
  - A word occupies 50*CLKS_PER_BIT cycles, or 70*CLKS_PER_BIT with eol.
- word_ready returns high on the same edge busy falls. A new word may be accepted on the next edge, giving a minimum of one idle cycle between words.
- ASCII bit 7 is always 0.
- Baud counter: width is ceil(log2(CLKS_PER_BIT)) bits; it counts 0..CLKS_PER_BIT-1 and wraps.

Test Plan:
- Reset held 5 cycles -> tx=1, word_ready=1, busy=0 throughout. Release, hold word_valid=0 for 100 cycles -> tx stays 1.
- CLKS_PER_BIT=4, word_in=octal 10 05 15 15 20, eol=0, one-cycle valid:
  - bench UART decoder sampling mid-bit receives 0x48 0x45 0x4C 0x4C 0x4F ("HELLO");
  - busy high exactly 200 cycles;
  - tx low on the cycle after acceptance.
- Same word with eol=1 -> seven bytes, ending 0x0D 0x0A; busy high 280 cycles.
- Translation sweep: codes 0,10,20,21,30,39,55,56,63 packed across two words -> ' ','#','%','&','0','9','\'','?','?'.
- word_valid held high continuously with changing word_in during a transfer -> only the first word is sent. The second accepted word is the value present on the cycle word_ready returns high.
- Assert reset during the DATA state of char 3 -> next cycle tx=1, ready=1, busy=0. A following word "ABCDE" (octal 01 02 03 04 05) is sent cleanly as 0x41..0x45.
